// File: rtl/switch_debounce_reader_pkg.sv
// Shared constants and debounce FSM state codes for the slide-switch conditioner.
package switch_debounce_reader_pkg;

    localparam int CLK_HZ        = 50_000_000;
    localparam int DB_CYCLES_DEF = 500_000;    // 10 ms at 50 MHz

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } db_state_e;

endpackage

// File: rtl/switch_debounce_reader_debounce_bit.sv
// One switch channel: 2-flop synchroniser, stability counter and level/rise/fall outputs.
module debounce_bit
    import switch_debounce_reader_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1_r, s2_r;
    db_state_e     state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          level_r, level_s;
    logic          rise_r, rise_s;
    logic          fall_r, fall_s;

    // Synchroniser, FSM state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r    <= 1'b0;
            s2_r    <= 1'b0;
            state_r <= ST_STABLE;
            cnt_r   <= {CW{1'b0}};
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            s1_r    <= raw;
            s2_r    <= s1_r;
            state_r <= state_s;
            cnt_r   <= cnt_s;
            level_r <= level_s;
            rise_r  <= rise_s;
            fall_r  <= fall_s;
        end
    end

    // Next-state logic: a new level is accepted only after DB_CYCLES consecutive mismatches.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        level_s = level_r;
        rise_s  = 1'b0;
        fall_s  = 1'b0;
        case (state_r)
            ST_STABLE: begin
                if (s2_r != level_r) begin
                    cnt_s   = CW'(1);
                    state_s = ST_COUNT;
                end else begin
                    cnt_s   = {CW{1'b0}};
                end
            end
            ST_COUNT: begin
                if (s2_r == level_r) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_STABLE;
                end else if (cnt_r == CNT_LAST) begin
                    level_s = s2_r;
                    rise_s  = s2_r;
                    fall_s  = ~s2_r;
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_STABLE;
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                cnt_s   = {CW{1'b0}};
                state_s = ST_STABLE;
            end
        endcase
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/switch_debounce_reader.sv
// Slide-switch conditioner: per-bit debounce plus a sticky change record with valid/ack.
// Optional accepted-edge counter port evt_count is built when SW_EVENT_COUNT_EN is defined.
module switch_debounce_reader
    import switch_debounce_reader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] sw_level,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_mask,
    input  logic             evt_ack
`ifdef SW_EVENT_COUNT_EN
    ,
    output logic [7:0]       evt_count
`endif
);

    logic [WIDTH-1:0] chg_s;
    logic             evt_valid_r, evt_valid_s;
    logic [WIDTH-1:0] evt_mask_r, evt_mask_s;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (SW[g]),
            .level (sw_level[g]),
            .rise  (sw_rise[g]),
            .fall  (sw_fall[g])
        );
    end

    assign chg_s = sw_rise | sw_fall;

    // Event record: bits accumulate until acked; an ack coinciding with new edges starts a fresh record.
    always_comb begin
        evt_valid_s = evt_valid_r;
        evt_mask_s  = evt_mask_r;
        if (!evt_valid_r) begin
            if (chg_s != {WIDTH{1'b0}}) begin
                evt_valid_s = 1'b1;
                evt_mask_s  = chg_s;
            end else begin
                evt_valid_s = 1'b0;
            end
        end else if (evt_ack) begin
            evt_valid_s = (chg_s != {WIDTH{1'b0}});
            evt_mask_s  = chg_s;
        end else begin
            evt_mask_s  = evt_mask_r | chg_s;
        end
    end

    // Event record registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_r <= 1'b0;
            evt_mask_r  <= {WIDTH{1'b0}};
        end else begin
            evt_valid_r <= evt_valid_s;
            evt_mask_r  <= evt_mask_s;
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_mask  = evt_mask_r;

`ifdef SW_EVENT_COUNT_EN
    logic [7:0] evt_count_r;

    function automatic logic [7:0] popcount(input logic [WIDTH-1:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    // Running count of accepted edges, wrapping modulo 256.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_count_r <= 8'd0;
        end else begin
            evt_count_r <= evt_count_r + popcount(chg_s);
        end
    end

    assign evt_count = evt_count_r;
`endif

endmodule

// File: tb/tb_switch_debounce_reader.sv
// Scoreboard bench for switch_debounce_reader with DB_CYCLES=4 (6-cycle SW-to-level latency).
module tb_switch_debounce_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] SW  = 8'h00;
    logic       evt_ack = 1'b0;
    logic [7:0] sw_level, sw_rise, sw_fall, evt_mask;
    logic       evt_valid;
`ifdef SW_EVENT_COUNT_EN
    logic [7:0] evt_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       r;
        logic [7:0] sw;
        logic       ack;
        logic [7:0] lvl;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       vld;
        logic [7:0] mask;
    } vec_t;

    vec_t sbq[$];

    switch_debounce_reader #(.WIDTH(8), .DB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .SW        (SW),
        .sw_level  (sw_level),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .evt_valid (evt_valid),
        .evt_mask  (evt_mask),
        .evt_ack   (evt_ack)
`ifdef SW_EVENT_COUNT_EN
        ,
        .evt_count (evt_count)
`endif
    );

    always #5 clk = ~clk;

    // Stimulus for one cycle plus the outputs expected right after that cycle's edge.
    function automatic void push(input logic r, input logic [7:0] sw, input logic ack,
                                 input logic [7:0] lvl, input logic [7:0] rise,
                                 input logic [7:0] fall, input logic vld, input logic [7:0] mask);
        vec_t v;
        v.r = r; v.sw = sw; v.ack = ack; v.lvl = lvl;
        v.rise = rise; v.fall = fall; v.vld = vld; v.mask = mask;
        sbq.push_back(v);
    endfunction

    task automatic test_reset();
        vec_t e;
        for (int i = 0; i < 10; i++) push(1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++)  push(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rst = e.r; SW = e.sw; evt_ack = e.ack;
            @(posedge clk); #1;
            vectors++;
            if (sw_level !== e.lvl || sw_rise !== e.rise || sw_fall !== e.fall ||
                evt_valid !== e.vld || evt_mask !== e.mask) begin
                miscompares++;
                $display("FAIL reset v%0d: got lvl=%h rise=%h fall=%h vld=%b mask=%h want lvl=%h rise=%h fall=%h vld=%b mask=%h",
                         vectors, sw_level, sw_rise, sw_fall, evt_valid, evt_mask,
                         e.lvl, e.rise, e.fall, e.vld, e.mask);
            end
        end
    endtask

    task automatic test_rise();
        vec_t e;
        for (int i = 0; i < 5; i++) push(1'b0, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
        push(1'b0, 8'h01, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0, 8'h00);
        push(1'b0, 8'h01, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 8'h01);
        push(1'b0, 8'h01, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 8'h01);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rst = e.r; SW = e.sw; evt_ack = e.ack;
            @(posedge clk); #1;
            vectors++;
            if (sw_level !== e.lvl || sw_rise !== e.rise || sw_fall !== e.fall ||
                evt_valid !== e.vld || evt_mask !== e.mask) begin
                miscompares++;
                $display("FAIL rise v%0d: got lvl=%h rise=%h fall=%h vld=%b mask=%h want lvl=%h rise=%h fall=%h vld=%b mask=%h",
                         vectors, sw_level, sw_rise, sw_fall, evt_valid, evt_mask,
                         e.lvl, e.rise, e.fall, e.vld, e.mask);
            end
        end
    endtask

    task automatic test_glitch();
        vec_t e;
        for (int i = 0; i < 3; i++) push(1'b0, 8'h05, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 8'h01);
        for (int i = 0; i < 8; i++) push(1'b0, 8'h01, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 8'h01);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rst = e.r; SW = e.sw; evt_ack = e.ack;
            @(posedge clk); #1;
            vectors++;
            if (sw_level !== e.lvl || sw_rise !== e.rise || sw_fall !== e.fall ||
                evt_valid !== e.vld || evt_mask !== e.mask) begin
                miscompares++;
                $display("FAIL glitch v%0d: got lvl=%h rise=%h fall=%h vld=%b mask=%h want lvl=%h rise=%h fall=%h vld=%b mask=%h",
                         vectors, sw_level, sw_rise, sw_fall, evt_valid, evt_mask,
                         e.lvl, e.rise, e.fall, e.vld, e.mask);
            end
        end
    endtask

    task automatic test_sticky_ack();
        vec_t e;
        // bit7 rises while 01 is pending
        for (int i = 0; i < 5; i++) push(1'b0, 8'h81, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 8'h01);
        push(1'b0, 8'h81, 1'b0, 8'h81, 8'h80, 8'h00, 1'b1, 8'h01);
        push(1'b0, 8'h81, 1'b0, 8'h81, 8'h00, 8'h00, 1'b1, 8'h81);
        // bit3 rises, still unacked
        for (int i = 0; i < 5; i++) push(1'b0, 8'h89, 1'b0, 8'h81, 8'h00, 8'h00, 1'b1, 8'h81);
        push(1'b0, 8'h89, 1'b0, 8'h89, 8'h08, 8'h00, 1'b1, 8'h81);
        push(1'b0, 8'h89, 1'b0, 8'h89, 8'h00, 8'h00, 1'b1, 8'h89);
        // bit3 falls; ack lands with the fall pulse
        for (int i = 0; i < 5; i++) push(1'b0, 8'h81, 1'b0, 8'h89, 8'h00, 8'h00, 1'b1, 8'h89);
        push(1'b0, 8'h81, 1'b0, 8'h81, 8'h00, 8'h08, 1'b1, 8'h89);
        push(1'b0, 8'h81, 1'b1, 8'h81, 8'h00, 8'h00, 1'b1, 8'h08);
        // plain ack clears, then ack with nothing pending is ignored
        push(1'b0, 8'h81, 1'b1, 8'h81, 8'h00, 8'h00, 1'b0, 8'h00);
        push(1'b0, 8'h81, 1'b1, 8'h81, 8'h00, 8'h00, 1'b0, 8'h00);
        push(1'b0, 8'h81, 1'b0, 8'h81, 8'h00, 8'h00, 1'b0, 8'h00);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rst = e.r; SW = e.sw; evt_ack = e.ack;
            @(posedge clk); #1;
            vectors++;
            if (sw_level !== e.lvl || sw_rise !== e.rise || sw_fall !== e.fall ||
                evt_valid !== e.vld || evt_mask !== e.mask) begin
                miscompares++;
                $display("FAIL sticky_ack v%0d: got lvl=%h rise=%h fall=%h vld=%b mask=%h want lvl=%h rise=%h fall=%h vld=%b mask=%h",
                         vectors, sw_level, sw_rise, sw_fall, evt_valid, evt_mask,
                         e.lvl, e.rise, e.fall, e.vld, e.mask);
            end
        end
        evt_ack = 1'b0;
    endtask

    task automatic test_rst_mid_count();
        vec_t e;
        push(1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) push(1'b0, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
        push(1'b1, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) push(1'b0, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
        push(1'b0, 8'h01, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0, 8'h00);
        push(1'b0, 8'h01, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 8'h01);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rst = e.r; SW = e.sw; evt_ack = e.ack;
            @(posedge clk); #1;
            vectors++;
            if (sw_level !== e.lvl || sw_rise !== e.rise || sw_fall !== e.fall ||
                evt_valid !== e.vld || evt_mask !== e.mask) begin
                miscompares++;
                $display("FAIL rst_mid v%0d: got lvl=%h rise=%h fall=%h vld=%b mask=%h want lvl=%h rise=%h fall=%h vld=%b mask=%h",
                         vectors, sw_level, sw_rise, sw_fall, evt_valid, evt_mask,
                         e.lvl, e.rise, e.fall, e.vld, e.mask);
            end
        end
    endtask

`ifdef SW_EVENT_COUNT_EN
    task automatic test_event_count();
        logic [7:0] cq[$];
        logic [7:0] exp_cnt;
        logic [7:0] model = 8'h00;
        rst = 1'b1; SW = 8'h00; evt_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int t = 1; t <= 32; t++) begin
            SW = (t % 2 == 1) ? 8'hFF : 8'h00;
            cq.push_back(model);          // after edge 6: pulses visible, count not yet bumped
            model = model + 8'd8;
            cq.push_back(model);          // after edge 7
            repeat (6) @(posedge clk);
            #1;
            exp_cnt = cq.pop_front();
            vectors++;
            if (evt_count !== exp_cnt || sw_level !== SW) begin
                miscompares++;
                $display("FAIL count_pre t%0d: got cnt=%h lvl=%h want cnt=%h lvl=%h",
                         t, evt_count, sw_level, exp_cnt, SW);
            end
            @(posedge clk); #1;
            exp_cnt = cq.pop_front();
            vectors++;
            if (evt_count !== exp_cnt) begin
                miscompares++;
                $display("FAIL count_post t%0d: got cnt=%h want cnt=%h", t, evt_count, exp_cnt);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_sticky_ack();
        test_rst_mid_count();
`ifdef SW_EVENT_COUNT_EN
        test_event_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
